// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch (IF) and the MEM stage.
// Latency: request seen in IDLE at cycle N -> ram_en at N+1 -> (ram_ready at N+1) -> valid at N+2.
// Backpressure: requesters hold their request until their valid pulse; stall_if/stall_pipe freeze the pipe.
// Ports: clk, rst_n (async, active-low); if_req/if_addr fetch request; mem_read/mem_write/mem_addr/
//        mem_wdata MEM-stage request; ram_en/ram_we/ram_addr/ram_wdata registered RAM command;
//        ram_rdata/ram_ready RAM response; if_rdata/if_valid, mem_rdata/mem_valid registered responses;
//        stall_if/stall_pipe combinational stalls; err one-cycle timeout flag.
// Option: define MEM_ARB_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES (1..15) cycles without
//         ram_ready; otherwise err is tied low and accesses wait indefinitely.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic        mem_valid,
    output logic        stall_if,
    output logic        stall_pipe,
    output logic        err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    localparam logic OWNER_MEM = 1'b0;
    localparam logic OWNER_IF  = 1'b1;

    state_t state;
    state_t state_nxt;
    logic   last_owner;   // requester served by the most recent completion
    logic   armed;        // low for the first posedge after reset release: no grant there
    logic   if_pend;
    logic   mem_pend;
    logic   grant_if;
    logic   grant_mem;
    logic   done;
    logic   timeout;

    assign stall_pipe = (mem_read | mem_write) & ~mem_valid;
    assign stall_if   = (if_req & ~if_valid) | stall_pipe;

    // A requester whose valid pulses this cycle is not eligible; if it still requests, that is
    // treated as a fresh request from the next cycle on.
    assign if_pend  = if_req & ~if_valid;
    assign mem_pend = stall_pipe;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] to_cnt;

    // Fires in the TIMEOUT_CYCLES-th ACC cycle if the RAM still has not answered.
    assign timeout = (state != IDLE) && !ram_ready && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err <= timeout;
            if (grant_if || grant_mem) begin
                to_cnt <= '0;
            end else if ((state != IDLE) && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 4'd1;
            end
        end
    end
`else
    // Parameter only matters for the timeout build.
    logic [3:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 4'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (armed) begin
                    if (if_pend && mem_pend) begin
                        grant_if  = (last_owner == OWNER_MEM);
                        grant_mem = (last_owner == OWNER_IF);
                    end else begin
                        grant_if  = if_pend;
                        grant_mem = mem_pend;
                    end
                    if (grant_if) begin
                        state_nxt = IF_ACC;
                    end else if (grant_mem) begin
                        state_nxt = MEM_ACC;
                    end
                end
            end
            IF_ACC, MEM_ACC: begin
                if (ram_ready || timeout) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            last_owner <= OWNER_MEM;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
        end else begin
            armed     <= 1'b1;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if (grant_if) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b0;
                ram_addr  <= if_addr;
                ram_wdata <= '0;
            end else if (grant_mem) begin
                ram_en    <= 1'b1;
                ram_we    <= mem_write;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
            end
            if (done) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                // A timed-out read returns zero data.
                if (state == IF_ACC) begin
                    last_owner <= OWNER_IF;
                    if_valid   <= 1'b1;
                    if_rdata   <= ram_ready ? ram_rdata : '0;
                end else begin
                    last_owner <= OWNER_MEM;
                    mem_valid  <= 1'b1;
                    if (!ram_we) begin
                        mem_rdata <= ram_ready ? ram_rdata : '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic        mem_valid;
    logic        stall_if;
    logic        stall_pipe;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .if_rdata(if_rdata), .mem_rdata(mem_rdata), .if_valid(if_valid), .mem_valid(mem_valid),
        .stall_if(stall_if), .stall_pipe(stall_pipe), .err(err)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0; ram_ready = 1'b0;
        step(); step();
        checks++; if ({ram_en, ram_we} !== 2'b00) begin errors++; $display("FAIL rst_cmd: got %b exp 00", {ram_en, ram_we}); end
        checks++; if ({ram_addr, ram_wdata} !== 64'd0) begin errors++; $display("FAIL rst_ram_bus: got %h exp 0", {ram_addr, ram_wdata}); end
        checks++; if ({if_rdata, mem_rdata} !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", {if_rdata, mem_rdata}); end
        checks++; if ({if_valid, mem_valid, stall_if, stall_pipe, err} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b exp 00000", {if_valid, mem_valid, stall_if, stall_pipe, err}); end
    endtask

    // Both requesters pending out of reset: IF first, MEM second, no grant on the first posedge.
    task automatic test_both_from_reset();
        if_req = 1'b1; if_addr = 32'h200; mem_read = 1'b1; mem_addr = 32'h300;
        ram_ready = 1'b1; ram_rdata = 32'h11111111;
        rst_n = 1'b1;
        step();
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL both_first_edge_en: got %b exp 0", ram_en); end
        step();
        checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL both_if_grant: got %b/%b/%h exp 1/0/200", ram_en, ram_we, ram_addr); end
        step();
        checks++; if ({if_valid, mem_valid} !== 2'b10) begin errors++; $display("FAIL both_if_valid: got %b exp 10", {if_valid, mem_valid}); end
        checks++; if (if_rdata !== 32'h11111111) begin errors++; $display("FAIL both_if_rdata: got %h exp 11111111", if_rdata); end
        ram_rdata = 32'h22222222;
        step();
        checks++; if ({ram_en, ram_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL both_mem_grant: got %b/%h exp 1/300", ram_en, ram_addr); end
        checks++; if ({if_valid, mem_valid} !== 2'b00) begin errors++; $display("FAIL both_no_valid: got %b exp 00", {if_valid, mem_valid}); end
        if_req = 1'b0;
        step();
        checks++; if ({if_valid, mem_valid} !== 2'b01) begin errors++; $display("FAIL both_mem_valid: got %b exp 01", {if_valid, mem_valid}); end
        checks++; if (mem_rdata !== 32'h22222222) begin errors++; $display("FAIL both_mem_rdata: got %h exp 22222222", mem_rdata); end
        mem_read = 1'b0; ram_ready = 1'b0;
        step();
        checks++; if ({ram_en, mem_valid} !== 2'b00) begin errors++; $display("FAIL both_end: got %b exp 00", {ram_en, mem_valid}); end
    endtask

    // Minimum-latency fetch; the request is left high during the valid cycle and must not be re-granted.
    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h40; ram_ready = 1'b1; ram_rdata = 32'h8C220004;
        step();
        checks++; if ({ram_en, ram_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL ifrd_en: got %b/%h exp 1/40", ram_en, ram_addr); end
        step();
        checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h8C220004}) begin errors++; $display("FAIL ifrd_valid: got %b/%h exp 1/8c220004", if_valid, if_rdata); end
        checks++; if ({stall_if, ram_en} !== 2'b00) begin errors++; $display("FAIL ifrd_stall_en: got %b exp 00", {stall_if, ram_en}); end
        if_req = 1'b0; ram_ready = 1'b0;
        step();
        checks++; if ({if_valid, ram_en} !== 2'b00) begin errors++; $display("FAIL ifrd_no_regrant: got %b exp 00", {if_valid, ram_en}); end
    endtask

    // Store with ram_ready held off for three ACC cycles.
    task automatic test_write_delayed();
        mem_write = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hCAFEF00D; ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 32'h100, 32'hCAFEF00D}) begin
                errors++; $display("FAIL wr_cmd_%0d: got %b/%b/%h/%h exp 1/1/100/cafef00d", i, ram_en, ram_we, ram_addr, ram_wdata);
            end
            checks++; if ({stall_pipe, mem_valid} !== 2'b10) begin errors++; $display("FAIL wr_stall_%0d: got %b exp 10", i, {stall_pipe, mem_valid}); end
        end
        ram_ready = 1'b1; ram_rdata = 32'hDEADBEEF;
        step();
        checks++; if ({mem_valid, stall_pipe, ram_en} !== 3'b100) begin errors++; $display("FAIL wr_done: got %b exp 100", {mem_valid, stall_pipe, ram_en}); end
        checks++; if (mem_rdata !== 32'h22222222) begin errors++; $display("FAIL wr_rdata_kept: got %h exp 22222222", mem_rdata); end
        mem_write = 1'b0; ram_ready = 1'b0;
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL wr_one_pulse: got %b exp 0", mem_valid); end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        mem_read = 1'b1; mem_addr = 32'h180; ram_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({ram_en, err, mem_valid} !== 3'b100) begin errors++; $display("FAIL to_wait_%0d: got %b exp 100", i, {ram_en, err, mem_valid}); end
            step();
        end
        checks++; if ({mem_valid, err, ram_en} !== 3'b110) begin errors++; $display("FAIL to_fire: got %b exp 110", {mem_valid, err, ram_en}); end
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL to_rdata: got %h exp 0", mem_rdata); end
        mem_read = 1'b0;
        step();
        checks++; if ({mem_valid, err} !== 2'b00) begin errors++; $display("FAIL to_pulse: got %b exp 00", {mem_valid, err}); end
    endtask
`else
    task automatic test_no_timeout();
        mem_read = 1'b1; mem_addr = 32'h180; ram_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            checks++; if ({ram_en, err, mem_valid} !== 3'b100) begin errors++; $display("FAIL nto_wait_%0d: got %b exp 100", i, {ram_en, err, mem_valid}); end
        end
        ram_ready = 1'b1; ram_rdata = 32'h5A5A1234;
        step();
        checks++; if ({mem_valid, err, mem_rdata} !== {2'b10, 32'h5A5A1234}) begin errors++; $display("FAIL nto_done: got %b/%b/%h exp 1/0/5a5a1234", mem_valid, err, mem_rdata); end
        mem_read = 1'b0; ram_ready = 1'b0;
        step();
    endtask
`endif

    // Reset asserted while MEM_ACC is waiting: access dropped at once, no valid, port idle afterwards.
    task automatic test_reset_mid_access();
        mem_read = 1'b1; mem_addr = 32'h1C0; ram_ready = 1'b0;
        step();
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rma_started: got %b exp 1", ram_en); end
        #2 rst_n = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h77777777;
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rma_async_en: got %b exp 0", ram_en); end
        step();
        checks++; if ({mem_valid, ram_en, mem_rdata} !== 34'd0) begin errors++; $display("FAIL rma_in_reset: got %b/%b/%h exp 0/0/0", mem_valid, ram_en, mem_rdata); end
        mem_read = 1'b0; ram_ready = 1'b0; rst_n = 1'b1;
        step(); step();
        checks++; if ({mem_valid, ram_en} !== 2'b00) begin errors++; $display("FAIL rma_after: got %b exp 00", {mem_valid, ram_en}); end
        if_req = 1'b1; if_addr = 32'h44; ram_ready = 1'b1; ram_rdata = 32'h0BADF00D;
        step();
        checks++; if ({ram_en, ram_addr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL rma_regrant: got %b/%h exp 1/44", ram_en, ram_addr); end
        step();
        checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL rma_fetch: got %b/%h exp 1/0badf00d", if_valid, if_rdata); end
        if_req = 1'b0; ram_ready = 1'b0;
        step();
    endtask

    // Random IF / MEM traffic against a RAM with random response delay. The model tracks the port
    // as free or serving one owner, who is owed a response, and the memory contents in program order.
    task automatic test_random();
        logic [31:0] ref_mem [16];
        logic [31:0] ram_arr [16];
        logic [31:0] v, if_a, mem_a, mem_d, exp_mrd, e_addr;
        logic [3:0]  idx;
        bit busy, owner, fin, idle_now, ip, mp, last_if, due_if, due_mem, n_if, n_mem, g_due, g_owner;
        bit if_act, mem_act, mem_w;
        int wait_left;
        busy = 0; owner = 0; last_if = 1; due_if = 0; due_mem = 0; g_due = 0; g_owner = 0;
        if_act = 0; mem_act = 0; mem_w = 0; if_a = '0; mem_a = '0; mem_d = '0; exp_mrd = '0;
        wait_left = 0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom; ref_mem[i] = v; ram_arr[i] = v;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            checks++; if ({if_valid, mem_valid} !== {due_if, due_mem}) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", cyc, {if_valid, mem_valid}, {due_if, due_mem}); end
            checks++; if (stall_pipe !== (mem_act & ~due_mem)) begin errors++; $display("FAIL rnd_stall_pipe@%0d: got %b exp %b", cyc, stall_pipe, mem_act & ~due_mem); end
            checks++; if (stall_if !== ((if_act & ~due_if) | (mem_act & ~due_mem))) begin errors++; $display("FAIL rnd_stall_if@%0d: got %b", cyc, stall_if); end
            if (due_if) begin
                checks++; if (if_rdata !== ref_mem[if_a[5:2]]) begin errors++; $display("FAIL rnd_if_rdata@%0d: got %h exp %h", cyc, if_rdata, ref_mem[if_a[5:2]]); end
                if_act = 0;
            end
            if (due_mem) begin
                if (mem_w) ref_mem[mem_a[5:2]] = mem_d;
                else exp_mrd = ref_mem[mem_a[5:2]];
                checks++; if (mem_rdata !== exp_mrd) begin errors++; $display("FAIL rnd_mem_rdata@%0d: got %h exp %h", cyc, mem_rdata, exp_mrd); end
                mem_act = 0;
            end
            if (g_due) begin
                busy = 1; owner = g_owner; wait_left = $urandom_range(0, 3);
            end
            checks++; if (ram_en !== busy) begin errors++; $display("FAIL rnd_ram_en@%0d: got %b exp %b", cyc, ram_en, busy); end
            if (busy) begin
                e_addr = owner ? if_a : mem_a;
                checks++;
                if (ram_addr !== e_addr || ram_we !== (!owner && mem_w) || (!owner && mem_w && ram_wdata !== mem_d)) begin
                    errors++; $display("FAIL rnd_cmd@%0d: got %h/%b/%h exp owner_if=%0b addr %h", cyc, ram_addr, ram_we, ram_wdata, owner, e_addr);
                end
            end
            // RAM side
            idle_now = !busy;
            fin = 0;
            if (busy) begin
                if (wait_left == 0) begin
                    idx = ram_addr[5:2]; ram_ready = 1'b1; ram_rdata = ram_arr[idx];
                    if (ram_we) ram_arr[idx] = ram_wdata;
                    fin = 1;
                end else begin
                    ram_ready = 1'b0; ram_rdata = $urandom; wait_left--;
                end
            end else begin
                ram_ready = ($urandom_range(0, 3) == 0); ram_rdata = $urandom;
            end
            // Clients
            if (!if_act && $urandom_range(0, 1) == 1) begin
                if_act = 1; if_a = 32'($urandom_range(0, 15)) << 2;
            end
            if (!mem_act && $urandom_range(0, 1) == 1) begin
                mem_act = 1; mem_w = ($urandom_range(0, 1) == 1);
                mem_a = 32'($urandom_range(0, 15)) << 2; mem_d = $urandom;
            end
            if_req = if_act; if_addr = if_a;
            mem_read = mem_act && !mem_w; mem_write = mem_act && mem_w;
            mem_addr = mem_a; mem_wdata = mem_d;
            // Expectations for the next cycle
            n_if = fin && owner; n_mem = fin && !owner;
            if (fin) begin last_if = owner; busy = 0; end
            g_due = 0;
            if (idle_now) begin
                ip = if_act && !due_if; mp = mem_act && !due_mem;
                if (ip && mp) begin g_due = 1; g_owner = !last_if; end
                else if (ip || mp) begin g_due = 1; g_owner = ip; end
            end
            due_if = n_if; due_mem = n_mem;
        end
    endtask

    initial begin
        test_reset();
        test_both_from_reset();
        test_if_read();
        test_write_delayed();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8: ready-wait limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1 bit: instruction-fetch read request, held until if_valid.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch address.
REQ-006 SHALL have ports mem_read and mem_write, input, 1 bit each: MEM-stage request from the EX/MEM register, held until mem_valid; never both 1.
REQ-007 SHALL have ports mem_addr and mem_wdata, input, 32 bits each: MEM-stage address and store data.
REQ-008 SHALL have ports ram_rdata, input, 32 bits, and ram_ready, input, 1 bit: shared single-port RAM read data and completion.
REQ-009 SHALL have ports ram_en, ram_we, output, 1 bit each, and ram_addr, ram_wdata, output, 32 bits each: registered RAM command.
REQ-010 SHALL have ports if_rdata, mem_rdata, output, 32 bits each, and if_valid, mem_valid, output, 1 bit each: registered responses.
REQ-011 SHALL have ports stall_if, stall_pipe, err, output, 1 bit each: fetch stall, full-pipeline stall, timeout error.

Function
REQ-012 SHALL implement FSM states IDLE, IF_ACC, MEM_ACC.
REQ-013 In IDLE, when only the MEM request is pending, SHALL go to MEM_ACC; when only if_req is pending, SHALL go to IF_ACC; when both are pending, SHALL grant the requester not served last (last_owner flag; reset value MEM, so IF wins first).
REQ-014 On a grant, SHALL register ram_addr, ram_wdata and ram_we from the winner, with ram_we=1 only for mem_write, and SHALL set ram_en=1 on the following cycle.
REQ-015 In an ACC state, SHALL hold ram_en, ram_we, ram_addr and ram_wdata stable until ram_ready=1.
REQ-016 On ram_ready=1 in an ACC state, SHALL drop ram_en, return to IDLE, and pulse the owner's valid for exactly one cycle on the next cycle.
REQ-017 On a read completion, SHALL capture ram_rdata into the owner's rdata register; on a write completion, mem_rdata SHALL remain unchanged.
REQ-018 SHALL give a minimum latency of request in IDLE at cycle N, ram_en at N+1, ram_ready at N+1, valid at N+2.
REQ-019 SHALL never re-grant a requester in the cycle its valid pulses; a request still asserted in that cycle SHALL count as a new request.
REQ-020 SHALL drive stall_pipe = (mem_read|mem_write) & ~mem_valid and stall_if = (if_req & ~if_valid) | stall_pipe, combinationally.
REQ-021 SHALL ignore ram_ready while in IDLE.
REQ-022 SHALL update last_owner only on a completion.

Reset
REQ-023 On rst_n=0, SHALL go to IDLE immediately and set all outputs, last_owner and the timeout counter to 0; last_owner=0 encodes MEM.
REQ-024 Reset mid-access SHALL abort the access with no valid pulse; after rst_n rises, the first grant SHALL occur no earlier than the second posedge.

Configuration
REQ-025 With MEM_ARB_TIMEOUT_EN defined, SHALL count cycles in an ACC state; on reaching TIMEOUT_CYCLES without ram_ready, SHALL return to IDLE, pulse the owner's valid with rdata=0, and pulse err for one cycle; the counter SHALL clear on each grant.
REQ-026 Without MEM_ARB_TIMEOUT_EN, SHALL wait for ram_ready indefinitely, SHALL tie err to 0 and SHALL contain no counter logic.

Verification
REQ-027 SHALL check: if_req=1, if_addr=0x40, ram_ready=1 with ram_rdata=0x8C220004 on the first ACC cycle -> ram_en at N+1, if_valid=1 with if_rdata=0x8C220004 at N+2, stall_if=0 at N+2.
REQ-028 SHALL check: if_req and mem_read both asserted from reset -> IF granted first, MEM second, with no cycle where both valids are 1.
REQ-029 SHALL check: mem_write=1, mem_addr=0x100, mem_wdata=0xCAFEF00D, ram_ready delayed 3 cycles -> ram_we=1 and the command stable for 3 cycles, mem_valid one pulse, mem_rdata unchanged, stall_pipe high until mem_valid.
REQ-030 SHALL check: rst_n pulled low during MEM_ACC -> ram_en=0 immediately, no mem_valid pulse, state IDLE.
REQ-031 SHALL check, with MEM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: mem_read with ram_ready held 0 -> err and mem_valid pulse, mem_rdata=0, after 4 ACC cycles.
REQ-032 SHALL check, without MEM_ARB_TIMEOUT_EN: the same stimulus as REQ-031 -> the access held 20+ cycles and err=0 throughout.
